// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, buffers {pc, instr} pairs in a small FIFO
// and hands them to decode over valid/ready; handles redirects, misalignment faults and halt.
//
// state   | meaning
// FETCH   | fetching sequentially while pc is inside instruction memory
// HALT    | pc ran past the end of memory; FIFO drains, waiting for a redirect
// FAULT   | misaligned redirect seen; frozen until reset
module fetch_controller #(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IMEM_BYTES = 64,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_HALT, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0]       fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fetch_count_q;
  logic              halted_q;
  logic              pop, push, flush;

  assign if_valid    = (count_q != '0);
  assign pop         = if_valid & if_ready;
  assign imem_addr   = pc_q;
  assign if_instr    = if_valid ? fifo_instr[rd_ptr_q] : '0;
  assign if_pc       = if_valid ? fifo_pc[rd_ptr_q] : '0;
  assign halted      = halted_q;
  assign fault       = (state_q == S_FAULT);
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_FETCH, S_HALT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_target[1:0] == 2'b00) begin
            pc_d    = redirect_target;
            state_d = S_FETCH;
          end else begin
            state_d = S_FAULT;
          end
        end else if (state_q == S_FETCH) begin
          if (pc_q <= LAST_PC) begin
            push = (count_q < DEPTH_C) | pop;
            if (push) pc_d = pc_q + ADDR_W'(4);
          end else begin
            state_d = S_HALT;
          end
        end
      end
      default: ;
    endcase
  end

  // A flush discards any same-cycle pop; otherwise count tracks push minus pop.
  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == S_HALT) && (count_d == '0);
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push) begin
          fifo_pc[wr_ptr_q]    <= pc_q;
          fifo_instr[wr_ptr_q] <= imem_instr;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
          fetch_count_q        <= fetch_count_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: stream, backpressure, redirect, end-of-memory halt,
// misaligned fault and asynchronous reset, against hand-computed expectations.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h00:  mem_word = 32'hF840_0182;
      64'h04:  mem_word = 32'hF840_01A3;
      64'h08:  mem_word = 32'hAA01_0285;
      64'h1C:  mem_word = 32'hB400_01A6;
      default: mem_word = {24'hC0DE00, a[7:0]};
    endcase
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = ready;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %0b want 0", if_valid); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr got %h want 0", if_instr); end
    n_checks++; if (if_pc !== 64'h0) begin n_fail++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", halted); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", fault); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_count got %0d want 0", fetch_count); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_i [3];
    exp_i[0] = 32'hF840_0182; exp_i[1] = 32'hF840_01A3; exp_i[2] = 32'hAA01_0285;
    do_reset(1'b1);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_cycle1_valid got %0b want 0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b want 1", i, if_valid); end
      n_checks++; if (if_pc !== 64'(4*i)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", i, if_pc, 4*i); end
      n_checks++; if (if_instr !== exp_i[i]) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", i, if_instr, exp_i[i]); end
    end
    n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stream_fetch_count got %0d want 3", fetch_count); end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL bp_imem_addr got %h want 8", imem_addr); end
    n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL bp_fetch_count got %0d want 2", fetch_count); end
    n_checks++; if (if_pc !== 64'h0 || if_instr !== 32'hF840_0182) begin n_fail++; $display("FAIL bp_head got %h/%h want 0/f8400182", if_pc, if_instr); end
    if_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'(4*i) || if_instr !== mem_word(64'(4*i)))
        begin n_fail++; $display("FAIL bp_resume[%0d] got v=%0b %h/%h want pc %h", i, if_valid, if_pc, if_instr, 4*i); end
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    if_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (if_pc !== 64'h4 || fetch_count !== 32'd3) begin n_fail++; $display("FAIL redir_setup got pc %h cnt %0d want 4/3", if_pc, fetch_count); end
    redirect_valid = 1'b1;
    redirect_target = 64'h1C;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid got %0b want 0", if_valid); end
    n_checks++; if (imem_addr !== 64'h1C) begin n_fail++; $display("FAIL redir_imem_addr got %h want 1c", imem_addr); end
    @(negedge clk);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'h1C || if_instr !== 32'hB400_01A6)
      begin n_fail++; $display("FAIL redir_head got v=%0b %h/%h want 1c/b40001a6", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_end_of_memory;
    logic [63:0] last_pc;
    int          seen;
    last_pc = '1;
    seen = 0;
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid) begin last_pc = if_pc; seen++; end
    end
    n_checks++; if (last_pc !== 64'h3C) begin n_fail++; $display("FAIL eom_last_pc got %h want 3c", last_pc); end
    n_checks++; if (seen != 16) begin n_fail++; $display("FAIL eom_delivered got %0d want 16", seen); end
    n_checks++; if (imem_addr !== 64'h40) begin n_fail++; $display("FAIL eom_imem_addr got %h want 40", imem_addr); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL eom_halted got %0b want 1", halted); end
    n_checks++; if (fetch_count !== 32'd16) begin n_fail++; $display("FAIL eom_fetch_count got %0d want 16", fetch_count); end
    redirect_valid = 1'b1;
    redirect_target = 64'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b0 || imem_addr !== 64'h20) begin n_fail++; $display("FAIL eom_resume got halted %0b addr %h want 0/20", halted, imem_addr); end
    @(negedge clk);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'h20) begin n_fail++; $display("FAIL eom_resume_head got v=%0b pc %h want 1/20", if_valid, if_pc); end
  endtask

  task automatic test_fault;
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_target = 64'h22;
    @(negedge clk);
    n_checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL fault_set got fault %0b v %0b want 1/0", fault, if_valid); end
    n_checks++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL fault_pc_hold got %h want 8", imem_addr); end
    redirect_target = 64'h10;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (fault !== 1'b1 || imem_addr !== 64'h8 || if_valid !== 1'b0)
      begin n_fail++; $display("FAIL fault_ignore_redirect got fault %0b addr %h v %0b want 1/8/0", fault, imem_addr, if_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (fault !== 1'b0 || imem_addr !== 64'h0) begin n_fail++; $display("FAIL fault_async_clear got fault %0b addr %h want 0/0", fault, imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (if_valid !== 1'b1 || imem_addr !== 64'h8) begin n_fail++; $display("FAIL mid_full got v %0b addr %h want 1/8", if_valid, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 64'h0 || fetch_count !== 32'd0)
      begin n_fail++; $display("FAIL mid_async got v %0b addr %h cnt %0d want 0/0/0", if_valid, imem_addr, fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'(4*i) || if_instr !== mem_word(64'(4*i)))
        begin n_fail++; $display("FAIL mid_restart[%0d] got v=%0b %h/%h want pc %h", i, if_valid, if_pc, if_instr, 4*i); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_end_of_memory();
    test_fault();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
